axis_stress_harness: RTL and testbench

AXIS_STRESS_HARNESS -- requirements
Module: axis_stress_harness

---
 rtl/harness_pkg.sv | 35 +++
 rtl/axis_sig_checker.sv | 71 +++++++
 rtl/axis_stress_harness.sv | 166 ++++++++++++++++
 tb/tb_axis_stress_harness.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/harness_pkg.sv
// Shared types and helpers for the AXI-Stream stress harness.
// Holds the generator state enum and the data-to-signature fold.
package harness_pkg;

  localparam int SIG_W_DEF  = 32;
  localparam int FOLD_MAX_W = 1024;
  localparam int SIG_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP,
    DONE
  } gen_state_e;

  typedef logic [FOLD_MAX_W-1:0] fold_in_t;
  typedef logic [SIG_MAX_W-1:0]  fold_out_t;

  // XOR of all sw-bit slices; callers zero-extend data and keep the low sw bits
  function automatic fold_out_t fold(input fold_in_t d, input int sw);
    fold_out_t r;
    fold_out_t m;
    fold_in_t  s;
    m = '1;
    m = m >> (SIG_MAX_W - sw);
    r = '0;
    s = d;
    for (int i = 0; i < FOLD_MAX_W / sw; i++) begin
      r = r ^ (s[SIG_MAX_W-1:0] & m);
      s = s >> sw;
    end
    return r;
  endfunction

endpackage

// File: rtl/axis_sig_checker.sv
// Sink-side checker: per-packet beat count, length errors,
// received packet count and rolling data signature.
module axis_sig_checker
  import harness_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int SIG_WIDTH  = SIG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tdata_i,
  input  logic                  tvalid_i,
  input  logic                  tready_i,
  input  logic                  tlast_i,
  input  logic [7:0]            exp_beats_i,
  output logic [SIG_WIDTH-1:0]  rx_pkts_o,
  output logic [SIG_WIDTH-1:0]  len_err_o,
  output logic [SIG_WIDTH-1:0]  sig_o
);

  logic [SIG_WIDTH-1:0] cnt_q, cnt_d;
  logic [SIG_WIDTH-1:0] rx_q, rx_d;
  logic [SIG_WIDTH-1:0] err_q, err_d;
  logic [SIG_WIDTH-1:0] sig_q, sig_d;
  logic [SIG_WIDTH-1:0] cnt_inc;
  logic [SIG_WIDTH-1:0] fold_w;
  fold_in_t             dext;
  fold_out_t            fres;

  always_comb begin
    dext                   = '0;
    dext[DATA_WIDTH-1:0]   = tdata_i;
    fres                   = fold(dext, SIG_WIDTH);
    fold_w                 = fres[SIG_WIDTH-1:0];
    cnt_inc                = cnt_q + 1'b1;
    cnt_d                  = cnt_q;
    rx_d                   = rx_q;
    err_d                  = err_q;
    sig_d                  = sig_q;
    if (tvalid_i && tready_i) begin
      sig_d = {sig_q[SIG_WIDTH-2:0], sig_q[SIG_WIDTH-1]} ^ fold_w;
      if (tlast_i) begin
        cnt_d = '0;
        rx_d  = rx_q + 1'b1;
        if (cnt_inc != SIG_WIDTH'(exp_beats_i))
          err_d = err_q + 1'b1;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      rx_q  <= '0;
      err_q <= '0;
      sig_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      rx_q  <= rx_d;
      err_q <= err_d;
      sig_q <= sig_d;
    end
  end

  assign rx_pkts_o = rx_q;
  assign len_err_o = err_q;
  assign sig_o     = sig_q;

endmodule

// File: rtl/axis_stress_harness.sv
// AXI-Stream stress harness: Johnson-pattern packet generator with
// gaps and packet limit, plus a backpressuring signature checker.
module axis_stress_harness
  import harness_pkg::*;
#(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int SIG_WIDTH  = SIG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_enable,
  input  logic [7:0]            cfg_pkt_beats,
  input  logic [7:0]            cfg_gap,
  input  logic [15:0]           cfg_pkt_count,
  input  logic [7:0]            cfg_bp_mask,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
  output logic                  m_axis_tvalid,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic [SIG_WIDTH-1:0]  tx_pkts,
  output logic [SIG_WIDTH-1:0]  rx_pkts,
  output logic [SIG_WIDTH-1:0]  len_err_cnt,
  output logic [SIG_WIDTH-1:0]  signature,
  output logic                  done
);

  gen_state_e            state_q, state_d;
  logic [7:0]            beats_q, beats_d;
  logic [7:0]            gap_q, gap_d;
  logic [15:0]           pcnt_q, pcnt_d;
  logic [7:0]            mask_q, mask_d;
  logic [7:0]            gcnt_q, gcnt_d;
  logic [7:0]            beat_q, beat_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [SIG_WIDTH-1:0]  tx_q, tx_d;
  logic [2:0]            bp_q, bp_d;
  logic                  done_q, done_d;
  logic                  accept;
  logic                  last_beat;
  logic                  hit_count;
  logic [SIG_WIDTH-1:0]  tx_inc;

  assign accept    = m_axis_tvalid & m_axis_tready;
  assign last_beat = (beat_q == beats_q - 8'd1);
  assign tx_inc    = tx_q + 1'b1;
  assign hit_count = (pcnt_q != 16'd0) &&
                     (tx_inc == SIG_WIDTH'(pcnt_q));

  always_comb begin
    state_d = state_q;
    beats_d = beats_q;
    gap_d   = gap_q;
    pcnt_d  = pcnt_q;
    mask_d  = mask_q;
    gcnt_d  = gcnt_q;
    beat_d  = beat_q;
    data_d  = data_q;
    tx_d    = tx_q;
    unique case (state_q)
      IDLE: begin
        if (cfg_enable) begin
          beats_d = (cfg_pkt_beats == 8'd0) ? 8'd1 : cfg_pkt_beats;
          gap_d   = cfg_gap;
          pcnt_d  = cfg_pkt_count;
          mask_d  = cfg_bp_mask;
          beat_d  = 8'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (accept) begin
          data_d = {data_q[DATA_WIDTH-2:0], ~data_q[DATA_WIDTH-1]};
          if (last_beat) begin
            beat_d = 8'd0;
            tx_d   = tx_inc;
            if (hit_count) begin
              state_d = DONE;
            end else if (!cfg_enable) begin
              state_d = IDLE;
            end else if (gap_q != 8'd0) begin
              state_d = GAP;
              gcnt_d  = gap_q - 8'd1;
            end
          end else begin
            beat_d = beat_q + 8'd1;
          end
        end
      end
      GAP: begin
        if (!cfg_enable)
          state_d = IDLE;
        else if (gcnt_q == 8'd0)
          state_d = SEND;
        else
          gcnt_d = gcnt_q - 8'd1;
      end
      DONE: begin
        if (!cfg_enable)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bp_d   = (state_q != IDLE) ? bp_q + 3'd1 : bp_q;
  assign done_d = (state_q == DONE) && (rx_pkts == tx_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      beats_q <= 8'd1;
      gap_q   <= '0;
      pcnt_q  <= '0;
      mask_q  <= '0;
      gcnt_q  <= '0;
      beat_q  <= '0;
      data_q  <= '0;
      tx_q    <= '0;
      bp_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      beats_q <= beats_d;
      gap_q   <= gap_d;
      pcnt_q  <= pcnt_d;
      mask_q  <= mask_d;
      gcnt_q  <= gcnt_d;
      beat_q  <= beat_d;
      data_q  <= data_d;
      tx_q    <= tx_d;
      bp_q    <= bp_d;
      done_q  <= done_d;
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tlast  = (state_q == SEND) && last_beat;
  assign m_axis_tdata  = data_q;
  assign m_axis_tkeep  = '1;
  assign s_axis_tready = (state_q != IDLE) && mask_q[bp_q];
  assign tx_pkts       = tx_q;
  assign done          = done_q;

  axis_sig_checker #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIG_WIDTH  (SIG_WIDTH)
  ) u_chk (
    .clk         (clk),
    .rst         (rst),
    .tdata_i     (s_axis_tdata),
    .tvalid_i    (s_axis_tvalid),
    .tready_i    (s_axis_tready),
    .tlast_i     (s_axis_tlast),
    .exp_beats_i (beats_q),
    .rx_pkts_o   (rx_pkts),
    .len_err_o   (len_err_cnt),
    .sig_o       (signature)
  );

endmodule

// File: tb/tb_axis_stress_harness.sv
// Bench for axis_stress_harness: stream-level model plus directed scenarios
// (loopback, gaps, stalls, length errors, backpressure, mid-packet reset).
module tb_axis_stress_harness;

  localparam int DW = 64;
  localparam int KW = 8;
  localparam int SW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_enable;
  logic [7:0]    cfg_pkt_beats;
  logic [7:0]    cfg_gap;
  logic [15:0]   cfg_pkt_count;
  logic [7:0]    cfg_bp_mask;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid;
  logic          m_tlast;
  logic          m_tready;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic          s_tlast;
  logic          s_tready;
  logic [SW-1:0] tx, rx, lerr, sig;
  logic          done;

  logic          lb, stall, tb_m_ready;
  logic [DW-1:0] tb_s_data;
  logic          tb_s_valid, tb_s_last;

  int            n_chk = 0;
  int            n_pass = 0;
  logic          chk_en = 1'b0;

  int            m_n, m_pb, m_beats;
  logic [SW-1:0] m_sig, m_tx, m_rx;

  always #5 clk = ~clk;

  assign m_tready = lb ? (s_tready & ~stall) : tb_m_ready;
  assign s_tdata  = lb ? m_tdata : tb_s_data;
  assign s_tvalid = lb ? (m_tvalid & ~stall) : tb_s_valid;
  assign s_tlast  = lb ? m_tlast : tb_s_last;

  axis_stress_harness #(
    .DATA_WIDTH (DW),
    .KEEP_WIDTH (KW),
    .SIG_WIDTH  (SW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .cfg_enable    (cfg_enable),
    .cfg_pkt_beats (cfg_pkt_beats),
    .cfg_gap       (cfg_gap),
    .cfg_pkt_count (cfg_pkt_count),
    .cfg_bp_mask   (cfg_bp_mask),
    .m_axis_tdata  (m_tdata),
    .m_axis_tkeep  (m_tkeep),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tlast  (m_tlast),
    .m_axis_tready (m_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tlast  (s_tlast),
    .s_axis_tready (s_tready),
    .tx_pkts       (tx),
    .rx_pkts       (rx),
    .len_err_cnt   (lerr),
    .signature     (sig),
    .done          (done)
  );

  // n-th value of a 64-bit Johnson sequence starting at zero
  function automatic logic [63:0] jc(input int n);
    int k;
    logic [63:0] v;
    k = n % 128;
    for (int i = 0; i < 64; i++)
      v[i] = (k <= 64) ? (i < k) : (i >= k - 64);
    return v;
  endfunction

  function automatic logic [31:0] mfold(input logic [63:0] d);
    return d[31:0] ^ d[63:32];
  endfunction

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_n   <= 0;
      m_pb  <= 0;
      m_sig <= '0;
      m_tx  <= '0;
      m_rx  <= '0;
    end else begin
      if (m_tvalid && m_tready) begin
        m_n <= m_n + 1;
        if (m_pb == m_beats - 1) begin
          m_pb <= 0;
          m_tx <= m_tx + 1;
        end else begin
          m_pb <= m_pb + 1;
        end
      end
      if (s_tvalid && s_tready) begin
        m_sig <= {m_sig[SW-2:0], m_sig[SW-1]} ^ mfold(s_tdata);
        if (s_tlast) m_rx <= m_rx + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("tdata", m_tdata, jc(m_n));
      check("tkeep", 64'(m_tkeep), 64'hFF);
      if (m_tvalid)
        check("tlast", 64'(m_tlast), 64'(m_pb == m_beats - 1));
      check("signature", 64'(sig), 64'(m_sig));
      check("tx_pkts", 64'(tx), 64'(m_tx));
      check("rx_pkts", 64'(rx), 64'(m_rx));
    end
  end

  task automatic do_reset();
    rst        = 1'b1;
    cfg_enable = 1'b0;
    lb         = 1'b0;
    stall      = 1'b0;
    tb_m_ready = 1'b0;
    tb_s_valid = 1'b0;
    tb_s_last  = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic start(input int b, input int g, input int c,
                       input int mk, input logic l);
    cfg_pkt_beats = 8'(b);
    cfg_gap       = 8'(g);
    cfg_pkt_count = 16'(c);
    cfg_bp_mask   = 8'(mk);
    m_beats       = (b == 0) ? 1 : b;
    lb            = l;
    cfg_enable    = 1'b1;
  endtask

  task automatic wait_beats(input int n, input int bound);
    logic found;
    found = 1'b0;
    for (int i = 0; i < bound && !found; i++) begin
      @(posedge clk);
      #1;
      if (m_n == n) found = 1'b1;
    end
    check("reach_beat", 64'(found), 64'd1);
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound && !done; i++) @(negedge clk);
    check("done", 64'(done), 64'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_tvalid"}, 64'(m_tvalid), 64'd0);
    check({tag, "_tlast"}, 64'(m_tlast), 64'd0);
    check({tag, "_tdata"}, m_tdata, 64'd0);
    check({tag, "_tkeep"}, 64'(m_tkeep), 64'hFF);
    check({tag, "_s_tready"}, 64'(s_tready), 64'd0);
    check({tag, "_tx"}, 64'(tx), 64'd0);
    check({tag, "_rx"}, 64'(rx), 64'd0);
    check({tag, "_lenerr"}, 64'(lerr), 64'd0);
    check({tag, "_sig"}, 64'(sig), 64'd0);
    check({tag, "_done"}, 64'(done), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv, first, last;
    logic [11:0] vpat;
    logic [7:0]  rpat;
    cfg_pkt_beats = '0;
    cfg_gap       = '0;
    cfg_pkt_count = '0;
    cfg_bp_mask   = '0;
    tb_s_data     = '0;
    m_beats       = 1;
    do_reset();
    @(negedge clk);
    check_reset_vals("reset");
    chk_en = 1'b1;

    // 4 x 24-beat packets, back to back
    @(posedge clk); #1;
    do_reset();
    start(24, 0, 4, 8'hFF, 1'b1);
    nv = 0; first = -1; last = -1;
    for (int i = 0; i < 130; i++) begin
      @(negedge clk);
      if (m_tvalid) begin
        if (first < 0) first = i;
        last = i;
        nv++;
      end
    end
    check("b2b_valid_cycles", 64'(nv), 64'd96);
    check("b2b_valid_run", 64'(last - first + 1), 64'd96);
    check("b2b_tx", 64'(tx), 64'd4);
    check("b2b_rx", 64'(rx), 64'd4);
    check("b2b_lenerr", 64'(lerr), 64'd0);
    check("b2b_done", 64'(done), 64'd1);

    // gap pattern
    @(posedge clk); #1;
    do_reset();
    start(3, 2, 2, 8'hFF, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      vpat[11-i] = m_tvalid;
    end
    check("gap_tvalid_pattern", 64'(vpat), 64'hE70);
    check("gap_tx", 64'(tx), 64'd2);
    check("gap_done", 64'(done), 64'd1);

    // five-cycle stall after beat 7
    @(posedge clk); #1;
    do_reset();
    start(24, 0, 1, 8'hFF, 1'b1);
    wait_beats(7, 40);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_tdata", m_tdata, 64'h7F);
      check("stall_tlast", 64'(m_tlast), 64'd0);
      check("stall_tvalid", 64'(m_tvalid), 64'd1);
    end
    @(posedge clk); #1;
    stall = 1'b0;
    wait_done(60);
    check("stall_tx", 64'(tx), 64'd1);
    check("stall_rx", 64'(rx), 64'd1);
    check("stall_lenerr", 64'(lerr), 64'd0);

    // externally driven sink: 5 beats against 4 expected, then 4
    @(posedge clk); #1;
    do_reset();
    start(4, 0, 0, 8'hFF, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      tb_s_data  = {32'(i * 7 + 3), 32'hA5A5_0000 | 32'(i)};
      tb_s_valid = 1'b1;
      tb_s_last  = (i == 4);
      @(posedge clk); #1;
    end
    tb_s_valid = 1'b0;
    tb_s_last  = 1'b0;
    @(negedge clk);
    check("len5_lenerr", 64'(lerr), 64'd1);
    check("len5_rx", 64'(rx), 64'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tb_s_data  = {32'hDEAD_0000 | 32'(i), 32'(i * 11)};
      tb_s_valid = 1'b1;
      tb_s_last  = (i == 3);
      @(posedge clk); #1;
    end
    tb_s_valid = 1'b0;
    tb_s_last  = 1'b0;
    @(negedge clk);
    check("len4_lenerr", 64'(lerr), 64'd1);
    check("len4_rx", 64'(rx), 64'd2);
    check("len4_tx", 64'(tx), 64'd0);

    // alternating sink ready
    @(posedge clk); #1;
    do_reset();
    start(8, 0, 1, 8'h55, 1'b1);
    @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      rpat[7-i] = s_tready;
    end
    check("bp55_ready_pattern", 64'(rpat), 64'hAA);
    wait_done(60);
    check("bp55_signature", 64'(sig), 64'h55);
    check("bp55_tx", 64'(tx), 64'd1);
    check("bp55_rx", 64'(rx), 64'd1);

    // reset during beat 10, then rerun
    @(posedge clk); #1;
    do_reset();
    start(24, 0, 0, 8'hFF, 1'b1);
    wait_beats(10, 40);
    rst        = 1'b1;
    cfg_enable = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_reset_vals("midrst");
    @(posedge clk); #1;
    start(2, 0, 1, 8'hFF, 1'b1);
    @(posedge clk);
    @(negedge clk);
    check("rerun_tvalid", 64'(m_tvalid), 64'd1);
    check("rerun_tdata0", m_tdata, 64'd0);
    wait_done(30);
    check("rerun_tx", 64'(tx), 64'd1);
    check("rerun_rx", 64'(rx), 64'd1);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
